conv_window_buffer: RTL
=======================

CONV_WINDOW_BUFFER -- requirements
Module: conv_window_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 32, pixels per image line (minimum 3).
REQ-003 SHALL have parameter IMG_HEIGHT, default 32, lines per frame (minimum 3).
REQ-004 SHALL have port in_Clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port in_Rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_Start, input, 1 bit: frame-start strobe.
REQ-007 SHALL have port in_Valid, input, 1 bit: in_Pixel is valid this cycle.
REQ-008 SHALL have port in_Pixel, input, DATA_WIDTH bits: raster-order pixel, unsigned.
REQ-009 SHALL have ports out_Win_00..out_Win_08, output, DATA_WIDTH bits each: 3x3 window in row-major order; 00 = top-left (oldest), 08 = bottom-right (newest).
REQ-010 SHALL have port out_Valid, output, 1 bit: the window is complete this cycle.
REQ-011 SHALL have port out_Done, output, 1 bit: one-cycle end-of-frame pulse.

Function
REQ-012 SHALL accept a pixel only on cycles with in_Valid=1; on in_Valid=0, counters, line buffers and window registers SHALL hold.
REQ-013 SHALL keep a column counter (0..IMG_WIDTH-1) and a row counter (0..IMG_HEIGHT-1) that address the accepted pixel.
REQ-014 SHALL advance the column counter on each accepted pixel; at IMG_WIDTH-1 it SHALL wrap to 0 and advance the row counter.
REQ-015 SHALL keep two line buffers of IMG_WIDTH entries, holding lines row-1 and row-2 at the current column.
REQ-016 SHALL shift each 3-entry window row left on an accept, loading (line row-2, line row-1, in_Pixel) at the current column into columns 0,3,6 -> 2,5,8.
REQ-017 SHALL register out_Valid=1 on the cycle after an accepted pixel at column>=2 and row>=2; otherwise out_Valid=0, and no window SHALL straddle two lines.
REQ-018 SHALL present the window on the same cycle as out_Valid, then hold it until the next accept (latency 1 cycle).
REQ-019 SHALL, on in_Start=1, zero both counters; if in_Valid=1 in that same cycle, the pixel SHALL be accepted as (row 0, column 0).
REQ-020 SHALL, on the pixel accepted at (IMG_HEIGHT-1, IMG_WIDTH-1), return both counters to 0 so the next accept starts a new frame.
REQ-021 SHALL NOT clear line-buffer contents on a frame boundary; rows 0-1 of each frame never produce out_Valid, so stale data is never output.

Reset
REQ-022 SHALL, while in_Rst=1, asynchronously force the counters, the out_Win_* registers, out_Valid and out_Done to 0.
REQ-023 SHALL leave line-buffer storage uninitialised at reset.
REQ-024 SHALL treat reset during a frame as a full abort; the first accepted pixel after reset SHALL be (row 0, column 0).

Configuration
REQ-025 SHALL, when macro CONV_WIN_DONE_EN is defined, pulse out_Done=1 for one cycle, registered, on the cycle after the frame's final pixel (REQ-020) is accepted.
REQ-026 SHALL, when CONV_WIN_DONE_EN is not defined, tie out_Done to constant 0 and instantiate no done logic; all other behaviour SHALL be unchanged.

Verification
REQ-027 SHALL cover: IMG_WIDTH=4, IMG_HEIGHT=4, in_Start then pixels 0..15 back-to-back -> exactly 4 out_Valid pulses with windows {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15}.
REQ-028 SHALL cover: the same frame with in_Valid dropped every other cycle -> identical 4 windows, with each out_Valid exactly one cycle after its accepting pixel, and outputs held during gaps.
REQ-029 SHALL cover: in_Rst asserted after pixel 9, then pixels 0..15 again -> no out_Valid before reset release, then the same 4 windows as REQ-027.
REQ-030 SHALL cover: in_Start with in_Valid asserted together at pixel 6 mid-frame, then 15 more pixels -> that pixel is treated as (0,0), and the first out_Valid follows the 11th pixel of the new frame.
REQ-031 SHALL cover: with CONV_WIN_DONE_EN defined, two back-to-back 4x4 frames -> out_Done high for exactly one cycle after pixel 15 of each frame, and 8 out_Valid pulses in total; without the macro, out_Done stays 0.

Source files
------------

// File: rtl/conv_window_buffer.sv
// conv_window_buffer: turns a raster-order pixel stream into 3x3 windows.
// Two line buffers hold the previous two image lines; a 3x3 register window
// shifts left on every accepted pixel. A window is flagged valid only when it
// lies entirely inside the current frame (column>=2, row>=2).
// Optional feature: define CONV_WIN_DONE_EN to get a registered one-cycle
// out_Done pulse after the last pixel of each frame; otherwise out_Done is 0.
//
// Handshake: in_Valid qualifies in_Pixel for one cycle; there is no
// backpressure, every cycle with in_Valid=1 accepts a pixel. out_Valid is a
// one-cycle flag (no ready), with the window held until the next accept.
module conv_window_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst,
  input  logic                  in_Start,
  input  logic                  in_Valid,
  input  logic [DATA_WIDTH-1:0] in_Pixel,
  output logic [DATA_WIDTH-1:0] out_Win_00,
  output logic [DATA_WIDTH-1:0] out_Win_01,
  output logic [DATA_WIDTH-1:0] out_Win_02,
  output logic [DATA_WIDTH-1:0] out_Win_03,
  output logic [DATA_WIDTH-1:0] out_Win_04,
  output logic [DATA_WIDTH-1:0] out_Win_05,
  output logic [DATA_WIDTH-1:0] out_Win_06,
  output logic [DATA_WIDTH-1:0] out_Win_07,
  output logic [DATA_WIDTH-1:0] out_Win_08,
  output logic                  out_Valid,
  output logic                  out_Done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          accept;
  logic          col_wrap;
  logic          row_wrap;
  logic          win_full;

  // Line buffers: lb1 holds line row-1, lb2 holds line row-2 (no reset).
  logic [DATA_WIDTH-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] tap1;
  logic [DATA_WIDTH-1:0] tap2;

  logic [DATA_WIDTH-1:0] win_q [9];
  logic [DATA_WIDTH-1:0] win_d [9];
  logic                  valid_q, valid_d;

  // Position of the pixel on the input this cycle; a start strobe makes it (0,0).
  always_comb begin
    accept   = in_Valid;
    cur_col  = in_Start ? '0 : col_q;
    cur_row  = in_Start ? '0 : row_q;
    col_wrap = (cur_col == COL_LAST);
    row_wrap = (cur_row == ROW_LAST);
    win_full = accept && (cur_col >= CW'(2)) && (cur_row >= RW'(2));
    tap1     = lb1_mem[cur_col];
    tap2     = lb2_mem[cur_col];
  end

  // Next column/row: advance on accept, wrap at line end and at frame end.
  always_comb begin
    col_d = cur_col;
    row_d = cur_row;
    if (accept) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_wrap ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
      end
    end
  end

  // Next window: each row shifts left, newest column comes from the taps.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      win_d[i] = win_q[i];
    end
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = tap2;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = tap1;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_Pixel;
    end
    valid_d = win_full;
  end

  // Counters, window registers and valid flag, asynchronously cleared.
  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Line buffers: push the accepted pixel down one line at its column.
  always_ff @(posedge in_Clk) begin
    if (accept) begin
      lb2_mem[cur_col] <= tap1;
      lb1_mem[cur_col] <= in_Pixel;
    end
  end

`ifdef CONV_WIN_DONE_EN
  logic done_q;

  // End-of-frame pulse, one cycle after the last pixel of the frame.
  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= accept && col_wrap && row_wrap;
    end
  end

  assign out_Done = done_q;
`else
  assign out_Done = 1'b0;
`endif

  assign out_Valid  = valid_q;
  assign out_Win_00 = win_q[0];
  assign out_Win_01 = win_q[1];
  assign out_Win_02 = win_q[2];
  assign out_Win_03 = win_q[3];
  assign out_Win_04 = win_q[4];
  assign out_Win_05 = win_q[5];
  assign out_Win_06 = win_q[6];
  assign out_Win_07 = win_q[7];
  assign out_Win_08 = win_q[8];

endmodule
